// File: rtl/axi_ram_responder.sv
// ---------------------------------------------------------------------------
// axi_ram_responder
//
// AXI4 slave backed by an on-chip word RAM. It is a stand-in for the DDR3
// controller so that AXI masters can be exercised without the PHY/DDR3 model.
// The write and read channels are independent. Each channel accepts one
// outstanding burst at a time.
//
// Ports
//   clock, reset_n          : clock, synchronous active-low reset
//   axi_aw*                 : write address channel (valid/ready/addr/id/len/burst)
//   axi_w*                  : write data channel (valid/ready/last/strb/data)
//   axi_b*                  : write response channel (valid/ready/resp/id)
//   axi_ar*                 : read address channel (valid/ready/addr/id/len/burst)
//   axi_r*                  : read data channel (valid/ready/last/resp/id/data)
//
// Addressing: the word index is addr[DEPTH_BITS+1:2]. Upper address bits are
// ignored, so memory aliases modulo depth. FIXED bursts hold the index. INCR
// bursts step the index and wrap modulo depth. WRAP and reserved bursts run to
// completion, but writes are dropped, reads return zero, and the response is
// SLVERR.
// ---------------------------------------------------------------------------
module axi_ram_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDRS      = 27,
    parameter int REQID      = 4,
    parameter int DEPTH_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 axi_awvalid_i,
    output logic                 axi_awready_o,
    input  logic [ADDRS-1:0]     axi_awaddr_i,
    input  logic [REQID-1:0]     axi_awid_i,
    input  logic [7:0]           axi_awlen_i,
    input  logic [1:0]           axi_awburst_i,
    input  logic                 axi_wvalid_i,
    output logic                 axi_wready_o,
    input  logic                 axi_wlast_i,
    input  logic [WIDTH/8-1:0]   axi_wstrb_i,
    input  logic [WIDTH-1:0]     axi_wdata_i,
    output logic                 axi_bvalid_o,
    input  logic                 axi_bready_i,
    output logic [1:0]           axi_bresp_o,
    output logic [REQID-1:0]     axi_bid_o,
    input  logic                 axi_arvalid_i,
    output logic                 axi_arready_o,
    input  logic [ADDRS-1:0]     axi_araddr_i,
    input  logic [REQID-1:0]     axi_arid_i,
    input  logic [7:0]           axi_arlen_i,
    input  logic [1:0]           axi_arburst_i,
    output logic                 axi_rvalid_o,
    input  logic                 axi_rready_i,
    output logic                 axi_rlast_o,
    output logic [1:0]           axi_rresp_o,
    output logic [REQID-1:0]     axi_rid_o,
    output logic [WIDTH-1:0]     axi_rdata_o
);

    localparam int LANES = WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_BUSY}         r_state_t;

    // Upper address bits and the byte offset take no part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_awaddr_i[ADDRS-1:DEPTH_BITS+2], axi_awaddr_i[1:0],
                                axi_araddr_i[ADDRS-1:DEPTH_BITS+2], axi_araddr_i[1:0]};

    // ------------------------------------------------------------------
    // Word RAM: byte-lane writes, registered read (read-before-write).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  mem_we;
    logic                  rd_en;
    logic [DEPTH_BITS-1:0] rd_idx;
    logic [WIDTH-1:0]      rd_data_q;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t              w_state_q, w_state_d;
    logic [REQID-1:0]      w_id_q, w_id_d;
    logic [DEPTH_BITS-1:0] w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d;
    logic                  w_fixed_q, w_fixed_d;
    logic                  w_bad_q, w_bad_d;
    logic [8:0]            w_cnt_q, w_cnt_d;
    logic [1:0]            bresp_q, bresp_d;

    always_comb begin
        w_state_d     = w_state_q;
        w_id_d        = w_id_q;
        w_idx_d       = w_idx_q;
        w_len_d       = w_len_q;
        w_fixed_d     = w_fixed_q;
        w_bad_d       = w_bad_q;
        w_cnt_d       = w_cnt_q;
        bresp_d       = bresp_q;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        mem_we        = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                axi_awready_o = 1'b1;
                if (axi_awvalid_i) begin
                    w_id_d    = axi_awid_i;
                    w_idx_d   = axi_awaddr_i[DEPTH_BITS+1:2];
                    w_len_d   = axi_awlen_i;
                    w_fixed_d = (axi_awburst_i == 2'b00);
                    w_bad_d   = axi_awburst_i[1];
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                axi_wready_o = 1'b1;
                if (axi_wvalid_i) begin
                    mem_we = !w_bad_q;
                    if (!w_fixed_q) begin
                        w_idx_d = w_idx_q + 1'b1;
                    end
                    // Saturate so an overlong burst can never alias to a legal count.
                    if (w_cnt_q != '1) begin
                        w_cnt_d = w_cnt_q + 9'd1;
                    end
                    if (axi_wlast_i) begin
                        w_state_d = W_RESP;
                        bresp_d   = (w_bad_q || (w_cnt_d != ({1'b0, w_len_q} + 9'd1)))
                                    ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                axi_bvalid_o = 1'b1;
                if (axi_bready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_fixed_q <= 1'b0;
            w_bad_q   <= 1'b0;
            w_cnt_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_fixed_q <= w_fixed_d;
            w_bad_q   <= w_bad_d;
            w_cnt_q   <= w_cnt_d;
            bresp_q   <= bresp_d;
        end
    end

    assign axi_bresp_o = axi_bvalid_o ? bresp_q : 2'b00;
    assign axi_bid_o   = axi_bvalid_o ? w_id_q  : '0;

    // RAM process. Reads sample the array before this edge's write lands,
    // so a same-word collision returns the old data.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (axi_wstrb_i[i]) begin
                    mem[w_idx_q][i*8 +: 8] <= axi_wdata_i[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Read channel.
    // A beat is issued to the RAM in cycle c. Its data sits in rd_data_q
    // during c+1 and is pushed into a 2-entry output buffer at the end of
    // c+1. The first beat is issued in the AR handshake cycle, straight from
    // axi_araddr_i, so rvalid rises two cycles after the handshake. A beat is
    // issued only when buffer occupancy plus in-flight beats, less any pop
    // this cycle, leaves a free slot. This gives one beat per cycle under
    // continuous rready and never overflows the buffer during a stall.
    // ------------------------------------------------------------------
    r_state_t              r_state_q, r_state_d;
    logic [REQID-1:0]      r_id_q, r_id_d;
    logic [DEPTH_BITS-1:0] r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic                  r_fixed_q, r_fixed_d;
    logic                  r_bad_q, r_bad_d;
    logic [8:0]            r_issued_q, r_issued_d;
    logic                  r_infl_q, r_infl_d;
    logic                  r_infl_last_q, r_infl_last_d;
    logic [1:0]            r_cnt_q, r_cnt_d;
    logic [WIDTH-1:0]      ent0_data_q, ent0_data_d, ent1_data_q, ent1_data_d;
    logic                  ent0_last_q, ent0_last_d, ent1_last_q, ent1_last_d;

    logic                  r_pop;
    logic [1:0]            r_cnt_after_pop;
    logic [1:0]            r_occ_after_pop;
    logic [WIDTH-1:0]      push_data;
    logic [DEPTH_BITS-1:0] ar_idx;

    assign ar_idx          = axi_araddr_i[DEPTH_BITS+1:2];
    assign r_pop           = (r_cnt_q != 2'd0) && axi_rready_i;
    assign r_cnt_after_pop = r_cnt_q - {1'b0, r_pop};
    assign r_occ_after_pop = r_cnt_after_pop + {1'b0, r_infl_q};
    assign push_data       = r_bad_q ? '0 : rd_data_q;

    always_comb begin
        r_state_d     = r_state_q;
        r_id_d        = r_id_q;
        r_idx_d       = r_idx_q;
        r_len_d       = r_len_q;
        r_fixed_d     = r_fixed_q;
        r_bad_d       = r_bad_q;
        r_issued_d    = r_issued_q;
        r_infl_d      = 1'b0;
        r_infl_last_d = 1'b0;
        rd_en         = 1'b0;
        rd_idx        = r_idx_q;
        axi_arready_o = 1'b0;

        // Output buffer: pop shifts entry 1 forward, push fills the first free slot.
        ent0_data_d = ent0_data_q;
        ent0_last_d = ent0_last_q;
        ent1_data_d = ent1_data_q;
        ent1_last_d = ent1_last_q;
        if (r_pop) begin
            ent0_data_d = ent1_data_q;
            ent0_last_d = ent1_last_q;
        end
        if (r_infl_q) begin
            if (r_cnt_after_pop == 2'd0) begin
                ent0_data_d = push_data;
                ent0_last_d = r_infl_last_q;
            end else begin
                ent1_data_d = push_data;
                ent1_last_d = r_infl_last_q;
            end
        end
        r_cnt_d = r_cnt_after_pop + {1'b0, r_infl_q};

        case (r_state_q)
            R_IDLE: begin
                axi_arready_o = 1'b1;
                if (axi_arvalid_i) begin
                    r_id_d        = axi_arid_i;
                    r_len_d       = axi_arlen_i;
                    r_fixed_d     = (axi_arburst_i == 2'b00);
                    r_bad_d       = axi_arburst_i[1];
                    rd_en         = 1'b1;
                    rd_idx        = ar_idx;
                    r_idx_d       = (axi_arburst_i == 2'b00) ? ar_idx : ar_idx + 1'b1;
                    r_issued_d    = 9'd1;
                    r_infl_d      = 1'b1;
                    r_infl_last_d = (axi_arlen_i == 8'd0);
                    r_state_d     = R_BUSY;
                end
            end
            R_BUSY: begin
                if ((r_issued_q != ({1'b0, r_len_q} + 9'd1)) && (r_occ_after_pop < 2'd2)) begin
                    rd_en         = 1'b1;
                    rd_idx        = r_idx_q;
                    r_idx_d       = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;
                    r_issued_d    = r_issued_q + 9'd1;
                    r_infl_d      = 1'b1;
                    r_infl_last_d = (r_issued_q == {1'b0, r_len_q});
                end
                if (r_pop && ent0_last_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state_q     <= R_IDLE;
            r_id_q        <= '0;
            r_idx_q       <= '0;
            r_len_q       <= '0;
            r_fixed_q     <= 1'b0;
            r_bad_q       <= 1'b0;
            r_issued_q    <= '0;
            r_infl_q      <= 1'b0;
            r_infl_last_q <= 1'b0;
            r_cnt_q       <= '0;
            ent0_data_q   <= '0;
            ent0_last_q   <= 1'b0;
            ent1_data_q   <= '0;
            ent1_last_q   <= 1'b0;
        end else begin
            r_state_q     <= r_state_d;
            r_id_q        <= r_id_d;
            r_idx_q       <= r_idx_d;
            r_len_q       <= r_len_d;
            r_fixed_q     <= r_fixed_d;
            r_bad_q       <= r_bad_d;
            r_issued_q    <= r_issued_d;
            r_infl_q      <= r_infl_d;
            r_infl_last_q <= r_infl_last_d;
            r_cnt_q       <= r_cnt_d;
            ent0_data_q   <= ent0_data_d;
            ent0_last_q   <= ent0_last_d;
            ent1_data_q   <= ent1_data_d;
            ent1_last_q   <= ent1_last_d;
        end
    end

    assign axi_rvalid_o = (r_cnt_q != 2'd0);
    assign axi_rdata_o  = axi_rvalid_o ? ent0_data_q : '0;
    assign axi_rlast_o  = axi_rvalid_o && ent0_last_q;
    assign axi_rresp_o  = (axi_rvalid_o && r_bad_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rid_o    = axi_rvalid_o ? r_id_q : '0;

endmodule

// File: tb/tb_axi_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_ram_responder
//
// Directed bench for axi_ram_responder. Inputs are driven on the falling edge,
// and outputs are sampled on the falling edge. Expected values are constants
// that were worked out by hand.
// ---------------------------------------------------------------------------
module tb_axi_ram_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        axi_awvalid_i = 1'b0;
    logic        axi_awready_o;
    logic [26:0] axi_awaddr_i = '0;
    logic [3:0]  axi_awid_i = '0;
    logic [7:0]  axi_awlen_i = '0;
    logic [1:0]  axi_awburst_i = '0;
    logic        axi_wvalid_i = 1'b0;
    logic        axi_wready_o;
    logic        axi_wlast_i = 1'b0;
    logic [3:0]  axi_wstrb_i = '0;
    logic [31:0] axi_wdata_i = '0;
    logic        axi_bvalid_o;
    logic        axi_bready_i = 1'b0;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_arvalid_i = 1'b0;
    logic        axi_arready_o;
    logic [26:0] axi_araddr_i = '0;
    logic [3:0]  axi_arid_i = '0;
    logic [7:0]  axi_arlen_i = '0;
    logic [1:0]  axi_arburst_i = '0;
    logic        axi_rvalid_o;
    logic        axi_rready_i = 1'b0;
    logic        axi_rlast_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;

    always #5 clock = ~clock;

    axi_ram_responder #(
        .WIDTH(32), .ADDRS(27), .REQID(4), .DEPTH_BITS(10)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
        .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_wlast_i(axi_wlast_i), .axi_wstrb_i(axi_wstrb_i), .axi_wdata_i(axi_wdata_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
        .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
        .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .axi_rlast_o(axi_rlast_o), .axi_rresp_o(axi_rresp_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rx_data [16];
    logic        rx_last [16];
    logic [1:0]  rx_resp [16];
    logic [3:0]  rx_id   [16];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start and end on a falling edge. Uses wd[]/ws[] for the beats.
    task automatic do_write(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats,
                            output logic [1:0] resp, output logic [3:0] bid);
        int n;
        axi_awvalid_i = 1'b1;
        axi_awaddr_i  = addr;
        axi_awid_i    = id;
        axi_awlen_i   = len;
        axi_awburst_i = burst;
        n = 0;
        while (!axi_awready_o && n < 50) begin @(negedge clock); n++; end
        check_value("aw_timeout", 64'(n < 50), 64'd1);
        @(posedge clock); @(negedge clock);
        axi_awvalid_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            axi_wvalid_i = 1'b1;
            axi_wdata_i  = wd[i];
            axi_wstrb_i  = ws[i];
            axi_wlast_i  = (i == nbeats - 1);
            n = 0;
            while (!axi_wready_o && n < 50) begin @(negedge clock); n++; end
            check_value("w_timeout", 64'(n < 50), 64'd1);
            @(posedge clock); @(negedge clock);
        end
        axi_wvalid_i = 1'b0;
        axi_wlast_i  = 1'b0;
        axi_bready_i = 1'b1;
        n = 0;
        while (!axi_bvalid_o && n < 50) begin @(negedge clock); n++; end
        check_value("b_timeout", 64'(n < 50), 64'd1);
        resp = axi_bresp_o;
        bid  = axi_bid_o;
        @(posedge clock); @(negedge clock);
        axi_bready_i = 1'b0;
        check_value("awready_after_b", 64'(axi_awready_o), 64'd1);
        check_value("bvalid_after_b", 64'(axi_bvalid_o), 64'd0);
        $display("write addr=0x%0h len=%0d burst=%0d beats=%0d -> bresp=%0d bid=%0d",
                 addr, len, burst, nbeats, resp, bid);
    endtask

    // When stall is set, rready is high only one cycle in three. Otherwise
    // rready is held high. Received beats go into the rx_* arrays.
    task automatic do_read(input logic [26:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input bit stall,
                           output int nrx, output int lat, output int gaps);
        int n;
        int k;
        bit seen;
        bit prev_stall;
        logic [31:0] prev_data;
        logic prev_last;
        axi_arvalid_i = 1'b1;
        axi_araddr_i  = addr;
        axi_arid_i    = id;
        axi_arlen_i   = len;
        axi_arburst_i = burst;
        n = 0;
        while (!axi_arready_o && n < 50) begin @(negedge clock); n++; end
        check_value("ar_timeout", 64'(n < 50), 64'd1);
        @(posedge clock); @(negedge clock);
        axi_arvalid_i = 1'b0;
        nrx = 0; lat = 0; gaps = 0; k = 1; seen = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        while (nrx < int'(len) + 1 && k < 300) begin
            axi_rready_i = stall ? (k % 3 == 2) : 1'b1;
            if (prev_stall) begin
                check_value("stall_data_stable", 64'(axi_rdata_o), 64'(prev_data));
                check_value("stall_last_stable", 64'(axi_rlast_o), 64'(prev_last));
            end
            if (axi_rvalid_o && !seen) begin seen = 1; lat = k; end
            if (seen && !axi_rvalid_o) gaps++;
            if (axi_rvalid_o && axi_rready_i) begin
                rx_data[nrx] = axi_rdata_o;
                rx_last[nrx] = axi_rlast_o;
                rx_resp[nrx] = axi_rresp_o;
                rx_id[nrx]   = axi_rid_o;
                nrx++;
            end
            prev_stall = axi_rvalid_o && !axi_rready_i;
            prev_data  = axi_rdata_o;
            prev_last  = axi_rlast_o;
            @(posedge clock); @(negedge clock);
            k++;
        end
        axi_rready_i = 1'b0;
        check_value("r_beat_count", 64'(nrx), 64'(int'(len) + 1));
        check_value("rvalid_after_last", 64'(axi_rvalid_o), 64'd0);
        check_value("arready_after_last", 64'(axi_arready_o), 64'd1);
        $display("read addr=0x%0h len=%0d burst=%0d stall=%0d -> beats=%0d latency=%0d",
                 addr, len, burst, stall, nrx, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  bid;
        int          nrx, lat, gaps;
        logic [31:0] exp4 [4];

        // Reset held low for three edges.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_value("rst_awready", 64'(axi_awready_o), 64'd1);
        check_value("rst_arready", 64'(axi_arready_o), 64'd1);
        check_value("rst_wready",  64'(axi_wready_o),  64'd0);
        check_value("rst_bvalid",  64'(axi_bvalid_o),  64'd0);
        check_value("rst_rvalid",  64'(axi_rvalid_o),  64'd0);
        check_value("rst_others",  64'({axi_bresp_o, axi_bid_o, axi_rlast_o, axi_rresp_o,
                                        axi_rid_o, axi_rdata_o}), 64'd0);

        // INCR write of four words at 0x0.
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(27'h0, 4'd1, 8'd3, 2'b01, 4, resp, bid);
        check_value("incr_w_bresp", 64'(resp), 64'd0);
        check_value("incr_w_bid",   64'(bid),  64'd1);

        // INCR read back with rready held high.
        do_read(27'h0, 4'd2, 8'd3, 2'b01, 1'b0, nrx, lat, gaps);
        check_value("incr_r_latency", 64'(lat), 64'd2);
        check_value("incr_r_gaps", 64'(gaps), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("incr_r_data%0d", i), 64'(rx_data[i]), 64'(wd[i]));
            check_value($sformatf("incr_r_last%0d", i), 64'(rx_last[i]), 64'(i == 3));
            check_value($sformatf("incr_r_rid%0d", i),  64'(rx_id[i]),   64'd2);
            check_value($sformatf("incr_r_resp%0d", i), 64'(rx_resp[i]), 64'd0);
        end

        // Byte strobes: write 0x44444444 at 0x8, then 0xAABBCCDD with lanes 0 and 2 enabled.
        wd[0] = 32'h44444444; ws[0] = 4'hF;
        do_write(27'h8, 4'd3, 8'd0, 2'b01, 1, resp, bid);
        check_value("strb_w1_bresp", 64'(resp), 64'd0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        do_write(27'h8, 4'd4, 8'd0, 2'b01, 1, resp, bid);
        check_value("strb_w2_bresp", 64'(resp), 64'd0);
        check_value("strb_w2_bid",   64'(bid),  64'd4);
        do_read(27'h8, 4'd5, 8'd0, 2'b01, 1'b0, nrx, lat, gaps);
        check_value("strb_r_data", 64'(rx_data[0]), 64'h44BB44DD);
        check_value("strb_r_last", 64'(rx_last[0]), 64'd1);

        // Backpressure read of four beats.
        exp4[0] = 32'h11111111; exp4[1] = 32'h22222222; exp4[2] = 32'h44BB44DD; exp4[3] = 32'h44444444;
        do_read(27'h0, 4'd6, 8'd3, 2'b01, 1'b1, nrx, lat, gaps);
        check_value("bp_r_latency", 64'(lat), 64'd2);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("bp_r_data%0d", i), 64'(rx_data[i]), 64'(exp4[i]));
            check_value($sformatf("bp_r_last%0d", i), 64'(rx_last[i]), 64'(i == 3));
            check_value($sformatf("bp_r_rid%0d", i),  64'(rx_id[i]),   64'd6);
        end

        // WRAP write: SLVERR, and memory is left unchanged.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(27'h0, 4'd7, 8'd0, 2'b10, 1, resp, bid);
        check_value("wrap_w_bresp", 64'(resp), 64'd2);
        check_value("wrap_w_bid",   64'(bid),  64'd7);
        do_read(27'h0, 4'd1, 8'd0, 2'b01, 1'b0, nrx, lat, gaps);
        check_value("wrap_w_mem_kept", 64'(rx_data[0]), 64'h11111111);

        // Short burst: awlen=3 with wlast on beat 2.
        wd[0] = 32'h55555555; wd[1] = 32'h66666666; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(27'h10, 4'd8, 8'd3, 2'b01, 2, resp, bid);
        check_value("short_w_bresp", 64'(resp), 64'd2);
        check_value("short_w_bid",   64'(bid),  64'd8);

        // Reserved read burst: two beats of zero with SLVERR.
        do_read(27'h0, 4'd9, 8'd1, 2'b11, 1'b0, nrx, lat, gaps);
        for (int i = 0; i < 2; i++) begin
            check_value($sformatf("rsv_r_data%0d", i), 64'(rx_data[i]), 64'd0);
            check_value($sformatf("rsv_r_resp%0d", i), 64'(rx_resp[i]), 64'd2);
            check_value($sformatf("rsv_r_last%0d", i), 64'(rx_last[i]), 64'(i == 1));
        end

        // Index wrap: two beats from word 1023 land at 1023 and 0.
        wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(27'hFFC, 4'd10, 8'd1, 2'b01, 2, resp, bid);
        check_value("wrapidx_w_bresp", 64'(resp), 64'd0);
        do_read(27'h0, 4'd11, 8'd0, 2'b01, 1'b0, nrx, lat, gaps);
        check_value("wrapidx_r_idx0", 64'(rx_data[0]), 64'h5A5A5A5A);
        do_read(27'hFFC, 4'd12, 8'd1, 2'b01, 1'b0, nrx, lat, gaps);
        check_value("wrapidx_r_beat0", 64'(rx_data[0]), 64'hA5A5A5A5);
        check_value("wrapidx_r_beat1", 64'(rx_data[1]), 64'h5A5A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_ram_responder.md
Name: axi_ram_responder

Overview:
- Synthesisable AXI4 slave (responder) backed by an on-chip word RAM.
- Answers the AXI4 write and read bursts produced by the bench initiators. Used as a drop-in stand-in for the DDR3 controller so AXI masters can be verified without the PHY/DDR3 model.
- Write and read channels are independent; each allows one outstanding burst.

Parameters:
- WIDTH, 32, data width in bits; byte lanes = WIDTH/8.
- ADDRS, 27, AXI byte-address width.
- REQID, 4, AXI ID width.
- DEPTH_BITS, 10, log2 of RAM depth in WIDTH-bit words.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- axi_awvalid_i  in  1  write-address valid
- axi_awready_o  out  1  write-address ready
- axi_awaddr_i  in  ADDRS  write byte address
- axi_awid_i  in  REQID  write ID
- axi_awlen_i  in  8  beats minus one
- axi_awburst_i  in  2  burst type
- axi_wvalid_i  in  1  write-data valid
- axi_wready_o  out  1  write-data ready
- axi_wlast_i  in  1  last write beat
- axi_wstrb_i  in  WIDTH/8  byte enables
- axi_wdata_i  in  WIDTH  write data
- axi_bvalid_o  out  1  write response valid
- axi_bready_i  in  1  write response ready
- axi_bresp_o  out  2  write response
- axi_bid_o  out  REQID  write response ID
- axi_arvalid_i  in  1  read-address valid
- axi_arready_o  out  1  read-address ready
- axi_araddr_i  in  ADDRS  read byte address
- axi_arid_i  in  REQID  read ID
- axi_arlen_i  in  8  beats minus one
- axi_arburst_i  in  2  burst type
- axi_rvalid_o  out  1  read data valid
- axi_rready_i  in  1  read data ready
- axi_rlast_o  out  1  last read beat
- axi_rresp_o  out  2  read response
- axi_rid_o  out  REQID  read ID
- axi_rdata_o  out  WIDTH  read data

Behaviour:
- Reset (reset_n low at a clock edge):
  - Both FSMs go to IDLE.
  - awready=1 and arready=1 from the first cycle after reset.
  - All other outputs are 0.
  - RAM contents are not cleared.
  - Reset mid-burst abandons the burst and no response is issued.
- Word index: addr[DEPTH_BITS+1:2]. Upper bits are ignored, so memory aliases modulo depth. addr[1:0] is ignored.
- Burst types:
  - FIXED (00): index is held for every beat.
  - INCR (01): index +1 per beat and wraps modulo depth.
  - WRAP (10) and reserved (11): the burst runs to completion, but writes are discarded and reads return 0. Response is SLVERR (2'b10).
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch ID, index, length and burst type; go to W_DATA.
  - W_DATA: awready=0, wready=1. Each W handshake writes the enabled byte lanes at the current index and increments the beat counter. On the wlast handshake go to W_RESP.
  - W_RESP: bvalid=1, bid=latched ID. bresp=OKAY (00), or SLVERR if beat count != awlen+1 or the burst type is illegal. Hold until bready, then go to W_IDLE; awready=1 in the next cycle.
- Write data: wstrb=0 beats are accepted and leave memory unchanged. Beats past awlen+1 (before wlast) continue at the next index.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch ID, index, length and burst type; go to R_BUSY.
  - R_BUSY: synchronous RAM read. First rvalid is asserted exactly 2 cycles after the AR handshake.
  - Output is a 2-entry skid buffer: rvalid, rdata, rlast and rresp stay stable while rready=0.
  - With rready held high, one beat per cycle, no bubbles.
  - rlast=1 on beat arlen. After the last handshake, go to R_IDLE; arready=1 next cycle.
- Simultaneous write and read to the same word in the same cycle: the read returns the old data.
- Write and read bursts proceed concurrently with no arbitration.

Test Plan:
- Reset: reset_n=0 for 3 cycles -> awready=arready=1, bvalid=rvalid=0, and all other outputs 0 on the first cycle after release.
- INCR write then read:
  - Write addr 0x0, awlen=3, awid=1, data 0x11111111, 0x22222222, 0x33333333, 0x44444444, wstrb=0xF -> bvalid with bid=1, bresp=00.
  - Read addr 0x0, arlen=3, arid=2 -> same 4 words in order, rlast on beat 4 only, rid=2, rresp=00; first rvalid 2 cycles after AR.
- Byte strobes: write 0xAABBCCDD to addr 0x8 with wstrb=0x5 over 0x44444444 -> readback 0x44BB44DD.
- Backpressure: read 4 beats with rready toggling 1,0,0,1,… -> data stable while stalled, no beat lost or duplicated, rlast only on beat 4.
- Errors:
  - awburst=10 -> bresp=10 and memory unchanged.
  - awlen=3 with wlast on beat 2 -> bresp=10.
  - arburst=11 with arlen=1 -> two beats of 0, rresp=10.
- Wrap-around: INCR write of 2 beats at word index 1023 (DEPTH_BITS=10) -> second beat lands at index 0; readback confirms both words.
